alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one combinational 32-bit alu between NREQ requesters. Round-robin
//   arbitration, valid/ready handshakes on both sides, and a 2-stage pipeline:
//   issue register -> alu -> result register. Sits between the requesting
//   units and the alu instance. Sustains one operation per cycle when the
//   response side is not stalled.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   IDW    2   requester-id width; must equal clog2(NREQ)
//   WIDTH  32  operand/result width; must match the alu (32)
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   NREQ       request i valid
//   req_ready  out  NREQ       request i accepted this cycle (at most one bit set)
//   req_op     in   3*NREQ     alu op of requester i, bits [3i+2:3i]
//   req_inp1   in   WIDTH*NREQ operand 1 of requester i
//   req_inp2   in   WIDTH*NREQ operand 2 of requester i
//   alu_op     out  3          to alu op
//   alu_inp1   out  WIDTH      to alu inp1
//   alu_inp2   out  WIDTH      to alu inp2
//   alu_outp   in   WIDTH      from alu outp (combinational)
//   rsp_valid  out  1          result available
//   rsp_ready  in   1          consumer takes result
//   rsp_id     out  IDW        requester that issued the result
//   rsp_data   out  WIDTH      alu result
//   busy       out  1          s1_valid | rsp_valid
// BEHAVIOUR
// - Reset (async, rst_n=0): s1_valid=0, rsp_valid=0, rsp_data=0, rsp_id=0,
//   s1 op/operands/id=0, rr pointer=NREQ-1 (requester 0 wins first), req_ready=0.
//   In-flight operations are discarded; no response is produced for them.
// - Stage 1 (issue reg): holds s1_valid, op, inp1, inp2, id. alu_op/alu_inp1/
//   alu_inp2 are driven from s1 regs. When s1_valid=0 they are driven to 0.
// - Stage 2 (result reg): rsp_valid, rsp_data, rsp_id.
// - s2_free = !rsp_valid | rsp_ready; s1_adv = s1_valid & s2_free;
//   s1_free = !s1_valid | s2_free.
// - Arbitration (combinational): when s1_free, grant the first i with
//   req_valid[i], searching ptr+1, ptr+2, ... mod NREQ. req_ready[i]=1 only for
//   the grantee. No grant when s1 is not free (req_ready=0).
// - Handshake req_valid[i]&req_ready[i] at edge N: s1 loads op/operands/id=i,
//   ptr<=i. Requesters hold valid and data stable until ready. Withdrawing
//   valid before ready is not allowed.
// - Edge N+1 (if s2_free): rsp_valid<=1, rsp_data<=alu_outp, rsp_id<=s1 id.
//   Latency from request handshake to rsp_valid is 2 cycles. Throughput is
//   1 op/cycle.
// - Stall: rsp_valid & !rsp_ready -> rsp_* hold stable, s1 holds, no grants.
// - Clear: s1_valid clears when s1_adv and there is no new grant. rsp_valid
//   clears when rsp_ready and !s1_adv.
// - Simultaneous: response pop, s1->s2 advance and a new accept in the same
//   cycle are all legal and required for full throughput.
// - Ordering: responses leave in acceptance order.
// - Fairness: a requester held valid is granted within NREQ handshakes.
// - Width: results are the alu's own 32-bit results. Add wraps mod 2^32.
//   Shift amounts are the full inp2.
// TESTING
// - req0 op=000 inp1=5 inp2=7, rsp_ready=1 -> rsp_valid 2 cycles after
//   handshake, rsp_data=12, rsp_id=0.
// - all 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0. After fill,
//   one rsp per cycle with rsp_id 0,1,2,3,0.
// - accept 2 ops, rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 once
//   both stages are full. Raise rsp_ready -> both results delivered in order,
//   none lost.
// - op coverage: 001 1,4->16; 010 0x80000000,31->1; 011 0xF0,0x3C->0x30;
//   100 0xF0,0x0F->0xFF; 101 0xFF,0x0F->0xF0; 110 0->0xFFFFFFFF; 111->1;
//   000 0xFFFFFFFF,1->0.
// - rst_n low with both stages full -> rsp_valid=0 and busy=0 immediately.
//   After release, with all requesting, req0 is granted first.
// - req2 held valid while req0 and req1 toggle every cycle -> req2 granted
//   within 4 handshakes.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Round-robin front end that shares one combinational ALU among
//             NREQ requesters through an issue register and a result register,
//             with valid/ready handshakes on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // requester side
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [3*NREQ-1:0]       req_op_i,
  input  logic [WIDTH*NREQ-1:0]   req_inp1_i,
  input  logic [WIDTH*NREQ-1:0]   req_inp2_i,
  // ALU side
  output logic [2:0]              alu_op_o,
  output logic [WIDTH-1:0]        alu_inp1_o,
  output logic [WIDTH-1:0]        alu_inp2_o,
  input  logic [WIDTH-1:0]        alu_outp_i,
  // response side
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IDW-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]        rsp_data_o,
  output logic                    busy_o
);

  localparam logic [IDW-1:0] C_PTR_RESET = IDW'(NREQ - 1);

  // Issue stage
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_inp1_q,  s1_inp1_d;
  logic [WIDTH-1:0] s1_inp2_q,  s1_inp2_d;
  logic [IDW-1:0]   s1_id_q,    s1_id_d;

  // Result stage
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;

  // Round-robin pointer: last requester granted
  logic [IDW-1:0]   ptr_q, ptr_d;

  // Pipeline flow control
  logic             s2_free;
  logic             s1_adv;
  logic             s1_free;

  // Arbitration results
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_inp1;
  logic [WIDTH-1:0] sel_inp2;

  // Requester index k positions after p, wrapping at NREQ
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return s[IDW-1:0];
  endfunction

  // Stage availability: result stage drains or is empty, issue stage can move
  always_comb begin
    s2_free = !rsp_valid_q || rsp_ready_i;
    s1_adv  = s1_valid_q && s2_free;
    s1_free = !s1_valid_q || s2_free;
  end

  // Round-robin search starting just after the last grantee; gated by reset
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (rst_ni && s1_free) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!grant_vld && req_valid_i[rr_idx(ptr_q, k)]) begin
          grant_vld = 1'b1;
          grant_id  = rr_idx(ptr_q, k);
        end
      end
    end
  end

  // One-hot ready toward the grantee only
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = grant_vld && (grant_id == IDW'(i));
    end
  end

  // Select the grantee's op and operands
  always_comb begin
    sel_op   = '0;
    sel_inp1 = '0;
    sel_inp2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_op   = req_op_i[3*i +: 3];
        sel_inp1 = req_inp1_i[WIDTH*i +: WIDTH];
        sel_inp2 = req_inp2_i[WIDTH*i +: WIDTH];
      end
    end
  end

  // Issue-stage next state: load on grant, empty when it advances unrefilled
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_inp1_d  = s1_inp1_q;
    s1_inp2_d  = s1_inp2_q;
    s1_id_d    = s1_id_q;
    ptr_d      = ptr_q;
    if (grant_vld) begin
      s1_valid_d = 1'b1;
      s1_op_d    = sel_op;
      s1_inp1_d  = sel_inp1;
      s1_inp2_d  = sel_inp2;
      s1_id_d    = grant_id;
      ptr_d      = grant_id;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Result-stage next state: capture ALU output on advance, drop on pop
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (s1_adv) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_outp_i;
      rsp_id_d    = s1_id_q;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Issue-stage and pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_inp1_q  <= '0;
      s1_inp2_q  <= '0;
      s1_id_q    <= '0;
      ptr_q      <= C_PTR_RESET;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_inp1_q  <= s1_inp1_d;
      s1_inp2_q  <= s1_inp2_d;
      s1_id_q    <= s1_id_d;
      ptr_q      <= ptr_d;
    end
  end

  // Result-stage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // ALU is fed only while the issue stage holds an operation
  always_comb begin
    alu_op_o   = s1_valid_q ? s1_op_q   : '0;
    alu_inp1_o = s1_valid_q ? s1_inp1_q : '0;
    alu_inp2_o = s1_valid_q ? s1_inp2_q : '0;
  end

  // Response and status outputs
  always_comb begin
    rsp_valid_o = rsp_valid_q;
    rsp_data_o  = rsp_data_q;
    rsp_id_o    = rsp_id_q;
    busy_o      = s1_valid_q || rsp_valid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Brief    : Self-checking bench for alu_arbiter with an ALU stub and a
//             queue-based model of accepted-but-unanswered operations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_inp1;
  logic [WIDTH*NREQ-1:0] req_inp2;
  logic [2:0]            alu_op;
  logic [WIDTH-1:0]      alu_inp1, alu_inp2, alu_outp;
  logic                  rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  logic [2:0]  op [NREQ];
  logic [31:0] ia [NREQ];
  logic [31:0] ib [NREQ];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  exp_t q[$];
  int   grant_log[$];
  int   mp;
  int   cyc;
  int   n_tests, n_fail;
  logic [NREQ-1:0] acc_mask;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_inp1_i(req_inp1), .req_inp2_i(req_inp2),
    .alu_op_o(alu_op), .alu_inp1_o(alu_inp1), .alu_inp2_o(alu_inp2),
    .alu_outp_i(alu_outp),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .busy_o(busy)
  );

  // Reference ALU behaviour (also serves as the ALU attached to the DUT)
  function automatic logic [31:0] alu_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a + b;
      3'd1: return a << b;
      3'd2: return a >> b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      default: return {31'b0, a < b};
    endcase
  endfunction

  always_comb alu_outp = alu_model(alu_op, alu_inp1, alu_inp2);

  // Pack per-requester fields onto the flat buses
  always_comb begin
    req_op   = '0;
    req_inp1 = '0;
    req_inp2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3]       = op[i];
      req_inp1[32*i +: 32]   = ia[i];
      req_inp2[32*i +: 32]   = ib[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First valid requester strictly after the last grantee, circularly
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Check the current cycle against the model, then advance one clock
  task automatic cycle();
    int   eg;
    logic exp_grant;
    logic [NREQ-1:0] exp_vec;
    #1;
    exp_grant = (|req_valid) && (q.size() < 2 || rsp_ready);
    eg        = exp_grant ? rr_pick(mp, req_valid) : -1;
    exp_vec   = '0;
    if (exp_grant) exp_vec[eg] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_vec));
    chk("busy", 64'(busy), 64'(q.size() > 0));
    if (q.size() > 0 && cyc > q[0].edge_no) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
    end else begin
      chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    end
    if (q.size() > 0 && cyc > q[0].edge_no && rsp_ready) void'(q.pop_front());
    acc_mask = '0;
    if (exp_grant) begin
      q.push_back('{id: 2'(eg), data: alu_model(op[eg], ia[eg], ib[eg]), edge_no: cyc + 1});
      mp = eg;
      grant_log.push_back(eg);
      acc_mask[eg] = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() > 0; t++) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic set_req(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op[i] = o;
    ia[i] = a;
    ib[i] = b;
  endtask

  logic [31:0] cov_a [8];
  logic [31:0] cov_b [8];
  logic [31:0] cov_r [8];
  int          hs;
  logic        got2;

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; mp = NREQ - 1;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; acc_mask = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 32'd0, 32'd0);

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_alu_inp1", 64'(alu_inp1), 64'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // ---- all four requesting: grant order 0,1,2,3,0 ----
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 32'(i * 10), 32'd1);
    grant_log.delete();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (5) cycle();
    chk("rr_count", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_order", 64'(grant_log[k]), 64'(k % NREQ));
    drain();

    // ---- single add, latency 2 ----
    set_req(0, 3'd0, 32'd5, 32'd7);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    #1;
    chk("lat_alu_op", 64'(alu_op), 64'd0);
    chk("lat_alu_inp1", 64'(alu_inp1), 64'd5);
    chk("lat_alu_inp2", 64'(alu_inp2), 64'd7);
    chk("lat_rsp_early", 64'(rsp_valid), 64'd0);
    cycle();
    chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("lat_rsp_data", 64'(rsp_data), 64'd12);
    chk("lat_rsp_id", 64'(rsp_id), 64'd0);
    drain();

    // ---- stall with both stages full ----
    rsp_ready = 1'b0;
    set_req(1, 3'd3, 32'hF0, 32'h3C);
    set_req(3, 3'd4, 32'hF0, 32'h0F);
    req_valid = 4'b0010; cycle();
    req_valid = 4'b1000; cycle();
    req_valid = 4'b0001;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("stall_no_grant", 64'(req_ready), 64'd0);
      chk("stall_rsp_data", 64'(rsp_data), 64'h30);
      cycle();
    end
    drain();

    // ---- op coverage with constant expectations ----
    cov_a = '{32'hFFFFFFFF, 32'd1, 32'h80000000, 32'hF0, 32'hF0, 32'hFF, 32'd0, 32'd3};
    cov_b = '{32'd1, 32'd4, 32'd31, 32'h3C, 32'h0F, 32'h0F, 32'd0, 32'd5};
    cov_r = '{32'd0, 32'd16, 32'd1, 32'h30, 32'hFF, 32'hF0, 32'hFFFFFFFF, 32'd1};
    for (int o = 0; o < 8; o++) begin
      set_req(o % NREQ, 3'(o), cov_a[o], cov_b[o]);
      req_valid = '0;
      req_valid[o % NREQ] = 1'b1;
      cycle();
      req_valid = '0;
      cycle();
      chk("op_cov", 64'(rsp_data), 64'(cov_r[o]));
      cycle();
    end
    drain();

    // ---- randomized traffic ----
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_req(i, 3'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom());
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      cycle();
    end
    drain();

    // ---- fairness: req2 held while req0/req1 toggle ----
    hs = 0; got2 = 1'b0;
    set_req(2, 3'd5, 32'h1234, 32'h00FF);
    for (int t = 0; t < 30 && !got2; t++) begin
      req_valid = {1'b0, 1'b1, 1'(t % 2 == 1), 1'(t % 2 == 0)};
      rsp_ready = 1'b1;
      cycle();
      if (acc_mask != '0) hs++;
      if (acc_mask[2]) got2 = 1'b1;
    end
    chk("fair_granted", 64'(got2), 64'd1);
    chk("fair_within_nreq", 64'(hs <= NREQ), 64'd1);
    drain();

    // ---- asynchronous reset with both stages full ----
    rsp_ready = 1'b0;
    set_req(0, 3'd0, 32'd1, 32'd2);
    set_req(1, 3'd0, 32'd3, 32'd4);
    req_valid = 4'b0001; cycle();
    req_valid = 4'b0010; cycle();
    req_valid = 4'hF;
    chk("prerst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    q.delete();
    mp = NREQ - 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("arst_first_grant", 64'(req_ready), 64'd1);
    cycle();
    req_valid = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
